// File: rtl/mano_dbg_pkg.sv
// Shared encodings for the debug/execution controller: controller states and mode select.
package mano_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_STEP_CYC   = 3'd2,
        ST_WAIT_INSTR = 3'd3,
        ST_BREAK      = 3'd4,
        ST_HALTED     = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        MODE_HALT       = 2'b00,
        MODE_RUN        = 2'b01,
        MODE_STEP_CYCLE = 2'b10,
        MODE_STEP_INSTR = 2'b11
    } exec_mode_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the active-low step button.
module btn_sync_edge (
    input  logic clk_1hz,
    input  logic reset,
    input  logic btn_n,
    output logic pulse
);

    logic       sync_p0;
    logic       sync_p1;
    logic       pressed;
    logic       pressed_p2;
    logic [1:0] warm;
    logic       armed;

    assign pressed = ~sync_p1;
    // A press is only honoured once a genuine released level has come through the
    // synchronizer, so a button held across reset release never produces a pulse.
    assign pulse   = pressed & ~pressed_p2 & armed;

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            pressed_p2 <= 1'b0;
            warm       <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync_p0    <= btn_n;
            sync_p1    <= sync_p0;
            pressed_p2 <= pressed;
            warm       <= {warm[0], 1'b1};
            if (warm[1] && sync_p1) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_controller.sv
// CPU execution controller: run/step/breakpoint/halt sequencing and enabled-cycle counter.
module exec_controller
    import mano_dbg_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk_1hz,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              step_btn_n,
    input  logic              fetch_start,
    input  logic              instr_done,
    input  logic              hlt_exec,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              fsm_clk_enable,
    output logic [2:0]        state,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_count
);

    ctrl_state_t cur_state;
    exec_mode_t  mode_e;
    logic        step_pulse;
    logic        bp_skip;
    logic        bp_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    btn_sync_edge u_btn (
        .clk_1hz (clk_1hz),
        .reset   (reset),
        .btn_n   (step_btn_n),
        .pulse   (step_pulse)
    );

    assign mode_e = exec_mode_t'(mode);
    assign state  = cur_state;
    assign bp_hit = (cur_state == ST_BREAK);

    always_comb begin
        bp_match       = (cur_state == ST_RUN) && bp_en && fetch_start &&
                         (pc == bp_addr) && !bp_skip;
        fsm_clk_enable = 1'b0;
        case (cur_state)
            ST_RUN:        fsm_clk_enable = (mode_e == MODE_RUN) && !bp_match;
            ST_STEP_CYC:   fsm_clk_enable = 1'b1;
            ST_WAIT_INSTR: fsm_clk_enable = (mode_e == MODE_STEP_INSTR);
            default:       fsm_clk_enable = 1'b0;
        endcase
    end

    // hlt_exec outranks everything; within a state, a mode change outranks breakpoint and step.
    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            cur_state   <= ST_IDLE;
            bp_skip     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (fsm_clk_enable) begin
                cycle_count <= sat_inc(cycle_count);
            end
            if (hlt_exec && cur_state != ST_HALTED) begin
                cur_state <= ST_HALTED;
                bp_skip   <= 1'b0;
            end else begin
                case (cur_state)
                    ST_IDLE: begin
                        bp_skip <= 1'b0;
                        if (mode_e == MODE_RUN) begin
                            cur_state <= ST_RUN;
                        end else if (step_pulse && mode_e == MODE_STEP_CYCLE) begin
                            cur_state <= ST_STEP_CYC;
                        end else if (step_pulse && mode_e == MODE_STEP_INSTR) begin
                            cur_state <= ST_WAIT_INSTR;
                        end
                    end
                    ST_RUN: begin
                        if (fsm_clk_enable) begin
                            bp_skip <= 1'b0;
                        end
                        if (mode_e != MODE_RUN) begin
                            cur_state <= ST_IDLE;
                        end else if (bp_match) begin
                            cur_state <= ST_BREAK;
                        end
                    end
                    ST_STEP_CYC: begin
                        cur_state <= ST_IDLE;
                    end
                    ST_WAIT_INSTR: begin
                        if (mode_e != MODE_STEP_INSTR || instr_done) begin
                            cur_state <= ST_IDLE;
                        end
                    end
                    ST_BREAK: begin
                        if (mode_e != MODE_RUN) begin
                            cur_state <= ST_IDLE;
                        end else if (step_pulse) begin
                            cur_state <= ST_RUN;
                            bp_skip   <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (mode_e == MODE_HALT) begin
                            cur_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        cur_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: every enabled CPU cycle is matched against a queued expectation.
module tb_exec_controller;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    logic              clk_1hz = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              step_btn_n;
    logic              fetch_start;
    logic              instr_done;
    logic              hlt_exec;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
    logic              fsm_clk_enable;
    logic [2:0]        state;
    logic              bp_hit;
    logic [CNT_W-1:0]  cycle_count;

    typedef struct packed {
        logic [2:0]       st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    exec_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_1hz        (clk_1hz),
        .reset          (reset),
        .mode           (mode),
        .step_btn_n     (step_btn_n),
        .fetch_start    (fetch_start),
        .instr_done     (instr_done),
        .hlt_exec       (hlt_exec),
        .pc             (pc),
        .bp_addr        (bp_addr),
        .bp_en          (bp_en),
        .fsm_clk_enable (fsm_clk_enable),
        .state          (state),
        .bp_hit         (bp_hit),
        .cycle_count    (cycle_count)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic expect_en(input logic [2:0] st, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic press(input int hold);
        step_btn_n = 1'b0;
        repeat (hold) tick();
        step_btn_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] target, input string name);
        int n;
        n = 0;
        while (state !== target && n < 20) begin
            tick();
            n++;
        end
        check(name, {29'd0, state}, {29'd0, target});
    endtask

    function automatic logic [CNT_W-1:0] sat_cnt(input int v);
        logic [31:0] w;
        w = v;
        return (v > 65535) ? 16'hFFFF : w[15:0];
    endfunction

    // Monitor: each enabled CPU cycle must match the next queued {state, count}.
    always @(negedge clk_1hz) begin
        exp_t e;
        if (reset === 1'b0 && fsm_clk_enable === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_enable: got state=%0d count=0x%0h, expected no enable",
                         state, cycle_count);
            end else begin
                e = exp_q.pop_front();
                if ({state, cycle_count} !== {e.st, e.cnt}) begin
                    n_bad++;
                    $display("FAIL enabled_cycle: got state=%0d count=0x%0h, expected state=%0d count=0x%0h",
                             state, cycle_count, e.st, e.cnt);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        mode        = 2'b00;
        step_btn_n  = 1'b1;
        fetch_start = 1'b0;
        instr_done  = 1'b0;
        hlt_exec    = 1'b0;
        pc          = '0;
        bp_addr     = '0;
        bp_en       = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_enable", {31'd0, fsm_clk_enable}, 32'd0);
        check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("rst_count", {16'd0, cycle_count}, 32'd0);
        repeat (3) tick();

        // Single-cycle step, button held for 5 cycles
        mode = 2'b10;
        tick();
        expect_en(3'd2, 16'd0);
        press(5);
        repeat (4) tick();
        check("step_cyc_state", {29'd0, state}, 32'd0);
        check("step_cyc_count", {16'd0, cycle_count}, 32'd1);
        check("step_cyc_drained", exp_q.size(), 32'd0);

        // Instruction step: instr_done on the 4th enabled cycle
        mode = 2'b11;
        tick();
        for (int k = 1; k <= 4; k++) expect_en(3'd3, k[CNT_W-1:0]);
        press(1);
        wait_state(3'd3, "wait_instr_entry");
        repeat (3) tick();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        check("step_instr_state", {29'd0, state}, 32'd0);
        check("step_instr_count", {16'd0, cycle_count}, 32'd5);
        check("step_instr_drained", exp_q.size(), 32'd0);

        // Breakpoint at 0x010, then resume without re-breaking
        bp_en   = 1'b1;
        bp_addr = 12'h010;
        pc      = 12'h00E;
        mode    = 2'b01;
        expect_en(3'd1, 16'd5);
        tick();
        check("run_entry", {29'd0, state}, 32'd1);
        tick();
        pc          = 12'h010;
        fetch_start = 1'b1;
        #1;
        check("bp_cycle_enable", {31'd0, fsm_clk_enable}, 32'd0);
        tick();
        check("break_state", {29'd0, state}, 32'd4);
        check("break_bp_hit", {31'd0, bp_hit}, 32'd1);
        check("break_enable", {31'd0, fsm_clk_enable}, 32'd0);
        check("break_count", {16'd0, cycle_count}, 32'd6);
        repeat (2) tick();
        check("break_hold", {29'd0, state}, 32'd4);
        expect_en(3'd1, 16'd6);
        press(1);
        wait_state(3'd1, "resume_run");
        check("resume_enable", {31'd0, fsm_clk_enable}, 32'd1);
        check("resume_bp_hit", {31'd0, bp_hit}, 32'd0);
        expect_en(3'd1, 16'd7);
        tick();
        pc          = 12'h011;
        fetch_start = 1'b0;
        check("no_rebreak", {29'd0, state}, 32'd1);

        // HLT while running
        hlt_exec = 1'b1;
        tick();
        hlt_exec = 1'b0;
        check("halt_state", {29'd0, state}, 32'd5);
        check("halt_enable", {31'd0, fsm_clk_enable}, 32'd0);
        check("halt_count", {16'd0, cycle_count}, 32'd8);
        repeat (3) tick();
        check("halt_hold", {29'd0, state}, 32'd5);
        mode = 2'b00;
        tick();
        check("halt_exit", {29'd0, state}, 32'd0);
        check("bp_halt_drained", exp_q.size(), 32'd0);

        // Run until the counter saturates
        bp_en = 1'b0;
        mode  = 2'b01;
        tick();
        for (int i = 0; i < 65529; i++) begin
            expect_en(3'd1, sat_cnt(8 + i));
            tick();
        end
        mode = 2'b00;
        tick();
        check("count_sat", {16'd0, cycle_count}, 32'h0000FFFF);
        check("sat_drained", exp_q.size(), 32'd0);

        // Reset in the middle of an instruction step, button held through release
        mode = 2'b11;
        tick();
        expect_en(3'd3, 16'hFFFF);
        press(1);
        wait_state(3'd3, "wait_before_reset");
        tick();
        check("wait_enable_pre_reset", {31'd0, fsm_clk_enable}, 32'd1);
        step_btn_n = 1'b0;
        reset      = 1'b1;
        #1;
        check("mid_rst_state", {29'd0, state}, 32'd0);
        check("mid_rst_count", {16'd0, cycle_count}, 32'd0);
        check("mid_rst_enable", {31'd0, fsm_clk_enable}, 32'd0);
        mode = 2'b10;
        repeat (3) tick();
        reset = 1'b0;
        repeat (6) tick();
        check("no_pulse_after_reset", {29'd0, state}, 32'd0);
        check("no_count_after_reset", {16'd0, cycle_count}, 32'd0);
        step_btn_n = 1'b1;
        repeat (3) tick();

        // A fresh press after release still steps
        expect_en(3'd2, 16'd0);
        press(2);
        repeat (5) tick();
        check("step_after_reset", {16'd0, cycle_count}, 32'd1);
        check("final_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the PC/breakpoint address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the cycle_count width.
REQ-003 clk_1hz  in  1  SHALL be the single system clock; all state on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 mode  in  2  SHALL select the mode: 00 HALT, 01 RUN, 10 STEP_CYCLE, 11 STEP_INSTR.
REQ-006 step_btn_n  in  1  SHALL be the raw, asynchronous, active-low step button.
REQ-007 fetch_start  in  1  SHALL indicate that the CPU sequence counter is at T0.
REQ-008 instr_done  in  1  SHALL indicate the last timing state of the current instruction.
REQ-009 hlt_exec  in  1  SHALL indicate that the CPU executed HLT.
REQ-010 pc  in  ADDR_W  SHALL carry the CPU program counter.
REQ-011 bp_addr  in  ADDR_W  SHALL carry the breakpoint address; bp_en  in  1  SHALL enable it.
REQ-012 fsm_clk_enable  out  1  SHALL be the CPU advance enable.
REQ-013 state  out  3  SHALL expose the current controller state; bp_hit  out  1  SHALL flag a breakpoint stop.
REQ-014 cycle_count  out  CNT_W  SHALL count enabled CPU cycles.

Function
REQ-015 step_btn_n SHALL pass through a 2-flop synchronizer, be inverted, and be edge-detected into step_pulse.
REQ-016 step_pulse SHALL be high for exactly one cycle per press, with 2-cycle latency from the first sampling edge that sees the button low; a held press SHALL yield one pulse.
REQ-017 The states SHALL be IDLE=0, RUN=1, STEP_CYC=2, WAIT_INSTR=3, BREAK=4, HALTED=5.
REQ-018 Transition priority SHALL be: hlt_exec, then mode change, then breakpoint, then step_pulse.
REQ-019 In any state other than HALTED, hlt_exec=1 SHALL move the controller to HALTED on the next edge.
REQ-020 IDLE SHALL go to RUN when mode=01, to STEP_CYC on step_pulse when mode=10, and to WAIT_INSTR on step_pulse when mode=11.
REQ-021 In RUN, bp_match SHALL equal bp_en & fetch_start & (pc==bp_addr) & ~bp_skip.
REQ-022 RUN SHALL go to BREAK on bp_match and to IDLE when mode!=01.
REQ-023 STEP_CYC SHALL last exactly one cycle and then return to IDLE.
REQ-024 WAIT_INSTR SHALL go to IDLE after a cycle with instr_done=1, or immediately when mode!=11.
REQ-025 BREAK SHALL go to RUN on step_pulse and set bp_skip; it SHALL go to IDLE when mode!=01.
REQ-026 HALTED SHALL go to IDLE only when mode=00.
REQ-027 fsm_clk_enable SHALL be combinational: 1 in RUN when mode=01 and ~bp_match; 1 in STEP_CYC; 1 in WAIT_INSTR when mode=11; 0 otherwise.
REQ-028 bp_skip SHALL clear after the first enabled cycle in RUN, so that resuming from a breakpoint does not re-trigger on the same pc.
REQ-029 bp_hit SHALL equal (state==BREAK).
REQ-030 cycle_count SHALL increment on each cycle with fsm_clk_enable=1, saturate at all-ones, and clear only on reset.

Reset
REQ-031 On reset: state=IDLE, bp_skip=0, cycle_count=0, synchronizer flops=released (1), edge-detect flop=0; therefore fsm_clk_enable=0 and bp_hit=0.
REQ-032 Reset asserted mid-operation SHALL abort any step or break immediately; no step_pulse SHALL be generated on reset release while the button is held.

Structure
REQ-033 Package mano_dbg_pkg SHALL hold the state encodings and mode encodings.
REQ-034 Sub-module btn_sync_edge SHALL implement the synchronizer and edge detector (REQ-015, REQ-016).

Verification
REQ-035 mode=10, press held 5 cycles -> exactly one fsm_clk_enable cycle, cycle_count 0->1, state returns to IDLE.
REQ-036 mode=11, instr_done asserted on the 4th enabled cycle -> exactly 4 enable cycles, then IDLE.
REQ-037 mode=01, bp_en=1, bp_addr=0x010, pc=0x010 with fetch_start -> enable=0 that cycle, state=BREAK, bp_hit=1; press -> RUN with enable=1 at pc 0x010 and no re-break.
REQ-038 mode=01, hlt_exec pulse -> HALTED with enable=0; mode=01 held keeps HALTED; mode=00 -> IDLE.
REQ-039 Preload cycle_count to 0xFFFE by running -> value stays at 0xFFFF; reset asserted mid-WAIT_INSTR -> IDLE, count=0, enable=0 immediately.
